lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store initiator between the MEM pipeline stage and the word-wide data memory (combinational read, posedge write).
//  Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses: extracts and extends load data, performs read-modify-write for SB/SH.
//  Flags misaligned, bad-funct3 and out-of-range accesses without touching memory. The pipeline stalls on !req_ready.
// PARAMETERS
//  MEM_WORDS  64  words in data memory; word index addr[31:2] >= MEM_WORDS is an access error
// PORTS
//  clk         in   1   clock
//  reset       in   1   reset, asynchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   controller idle, request accepted this cycle if req_valid
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   RV32I width/sign code
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data (low byte/half used for SB/SH)
//  resp_valid  out  1   one-cycle completion pulse
//  resp_err    out  1   valid with resp_valid: access rejected
//  resp_rdata  out  32  extended load data; held until next successful load completes
//  mem_a       out  32  memory byte address, always word aligned
//  mem_we      out  1   memory write enable
//  mem_wd      out  32  memory write data
//  mem_rd      in   32  memory read data (combinational from mem_a)
// BEHAVIOUR
//  Reset: state IDLE; resp_valid=0, resp_err=0, resp_rdata=0, all latched request regs 0; mem_we=0, mem_a=0, mem_wd=0.
//  Accept: req_valid && req_ready (ready==(state==IDLE)) latches we, funct3, addr, wdata; inputs need not be held afterwards.
//  Error check at accept: load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010};
//   W with addr[1:0]!=0; H/HU with addr[0]!=0; addr[31:2] >= MEM_WORDS. Error -> DONE with err=1, no memory access.
//  FSM: IDLE, RD, WR, DONE.
//   load:   IDLE -> RD -> DONE. In RD, mem_a={addr_q[31:2],2'b00}; resp_rdata registered from mem_rd at end of RD.
//   SW:     IDLE -> WR -> DONE.
//   SB/SH:  IDLE -> RD (capture mem_rd into word_q) -> WR -> DONE.
//   WR: mem_we=1, mem_a as RD, mem_wd = SW: wdata_q; SB: word_q with lane addr_q[1:0] replaced by wdata_q[7:0];
//       SH: word_q with half addr_q[1] replaced by wdata_q[15:0].
//   DONE: resp_valid=1, resp_err as latched; next state IDLE unconditionally (no back-to-back accept in DONE).
//  Latency accept->resp_valid: load 2, SW 2, SB/SH 3, error 1 cycle.
//  Load extract: B/BU byte at addr_q[1:0]*8; H/HU half at addr_q[1]*16; B/H sign-extend, BU/HU zero-extend, W as-is.
//  mem_we asserted only in WR; mem_a/mem_wd are 0 outside RD/WR. Error responses leave resp_rdata unchanged.
//  Reset mid-operation: immediate return to IDLE, mem_we drops at once, no resp_valid for aborted request.
//  A read and write never occur in the same cycle; no write forwarding needed (RMW is atomic w.r.t. this sole initiator).
// STRUCTURE
//  lsu_pkg: funct3 constants F3_B=000,F3_H=001,F3_W=010,F3_BU=100,F3_HU=101; state enum lsu_state_t {IDLE,RD,WR,DONE}.
//  Sub-module lsu_align (combinational): load extract/extend(word,funct3,off) and store merge(word,data,funct3,off).
//  lsu_mem_ctrl holds FSM, request regs, word_q, resp regs, error check.
// TESTING
//  Bench pairs lsu_mem_ctrl with a 64-word behavioural memory, reset asserted then released.
//  SW addr 0x8 data 0xDEADBEEF -> mem_we one cycle, RAM[2]=0xDEADBEEF, resp_valid 2 cycles after accept, err=0.
//  Then LB 0xB -> resp_rdata 0xFFFFFFDE; LBU 0xB -> 0x000000DE; LH 0x8 -> 0xFFFFBEEF; LHU 0xA -> 0x0000DEAD; LW 0x8 -> 0xDEADBEEF.
//  SB 0x9 data 0x12 then SH 0xA data 0x5678 -> RAM[2]=0x5678_12EF, each resp at accept+3, RAM[1],RAM[3] unchanged.
//  LW 0x6, LH 0x5, SW 0x102 (word 64), load funct3=011 -> err=1 at accept+1, mem_we never high, resp_rdata unchanged.
//  Reset asserted during WR of an SB -> mem_we low immediately, state IDLE, no resp_valid, req_ready=1 after release.
//  req_valid held high over 3 back-to-back loads -> each accepted only when req_ready=1, one resp_valid per request, in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states
// and the access legality check applied when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} lsu_state_t;

  // The access is rejected if any of these hold: the width code is illegal
  // for the direction, the address is misaligned for the width, or the word
  // index falls outside the memory.
  function automatic logic access_err(input logic        we,
                                      input logic [2:0]  f3,
                                      input logic [31:0] addr,
                                      input int unsigned words);
    logic bad_f3;
    logic misaligned;
    logic out_of_range;
    if (we) bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
    else    bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    case (f3)
      F3_W:       misaligned = (addr[1:0] != 2'b00);
      F3_H, F3_HU: misaligned = addr[0];
      default:    misaligned = 1'b0;
    endcase
    out_of_range = (addr[31:2] >= 30'(words));
    return bad_f3 || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering between byte/half/word accesses and the word-wide memory:
// load extract with sign/zero extension, and store merge into a read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [31:0] st_word,
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] ld_data,
  output logic [31:0] st_merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte/half out of the read word and extend it.
  always_comb begin
    case (off)
      2'd0:    sel_byte = ld_word[7:0];
      2'd1:    sel_byte = ld_word[15:8];
      2'd2:    sel_byte = ld_word[23:16];
      default: sel_byte = ld_word[31:24];
    endcase
    sel_half = off[1] ? ld_word[31:16] : ld_word[15:0];
    case (funct3)
      F3_B:    ld_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   ld_data = {24'h0, sel_byte};
      F3_H:    ld_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   ld_data = {16'h0, sel_half};
      default: ld_data = ld_word;
    endcase
  end

  // Replace only the addressed lane of the previously read word; SW passes through.
  always_comb begin
    st_merged = st_word;
    case (funct3)
      F3_B: begin
        case (off)
          2'd0:    st_merged[7:0]   = data[7:0];
          2'd1:    st_merged[15:8]  = data[7:0];
          2'd2:    st_merged[23:16] = data[7:0];
          default: st_merged[31:24] = data[7:0];
        endcase
      end
      F3_H: begin
        if (off[1]) st_merged[31:16] = data[15:0];
        else        st_merged[15:0]  = data[15:0];
      end
      default: st_merged = data;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a word-wide data memory.
//
//   state | meaning
//   IDLE  | ready for a request; legality checked on accept
//   RD    | memory word read (load result, or old word for SB/SH)
//   WR    | memory write of full word or merged word
//   DONE  | one-cycle response, back to IDLE
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_t  state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] ld_data;
  logic [31:0] st_merged;

  lsu_align u_align (
    .ld_word   (mem_rd),
    .st_word   (word_q),
    .data      (wdata_q),
    .funct3    (funct3_q),
    .off       (addr_q[1:0]),
    .ld_data   (ld_data),
    .st_merged (st_merged)
  );

  assign req_ready = (state == IDLE);

  // Memory port is driven only in RD/WR so that an async reset drops it at once.
  always_comb begin
    mem_a  = 32'h0;
    mem_we = 1'b0;
    mem_wd = 32'h0;
    if (state == RD || state == WR) mem_a = {addr_q[31:2], 2'b00};
    if (state == WR) begin
      mem_we = 1'b1;
      mem_wd = st_merged;
    end
  end

  // Sequencer: request capture, read/modify/write steps and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      word_q     <= 32'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (access_err(req_we, req_funct3, req_addr, MEM_WORDS)) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we && req_funct3 == F3_W) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            word_q <= mem_rd;
            state  <= WR;
          end else begin
            resp_rdata <= ld_data;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            state      <= DONE;
          end
        end
        WR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          state      <= DONE;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 64-word behavioural data memory.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] ram [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_a      (mem_a),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = ram[mem_a[7:2]];

  // Memory: known pattern while reset is high, posedge write otherwise.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= {8'(i), 8'hA5, 8'(i), 8'h5A};
    end else if (mem_we) begin
      ram[mem_a[7:2]] <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request: wait for ready, present for one edge, then count cycles to resp.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic err,
                        output int we_cycles);
    int w;
    lat = 99;
    err = 1'b0;
    we_cycles = 0;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_we) we_cycles++;
      if (resp_valid) begin
        lat = c;
        err = resp_err;
        break;
      end
    end
  endtask

  int          lat;
  logic        err;
  int          wec;
  logic [31:0] ld_exp [3];
  logic [31:0] ld_addr [3];
  logic [2:0]  ld_f3 [3];

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_a", mem_a, 32'h0);
    reset = 1'b0;

    do_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, lat, err, wec);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", 32'(err), 32'd0);
    chk("sw_we_cycles", 32'(wec), 32'd1);
    chk("sw_ram2", ram[2], 32'hDEADBEEF);
    chk("idle_mem_a", mem_a, 32'h0);

    do_req(1'b0, 3'b000, 32'hB, 32'h0, lat, err, wec);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_data", resp_rdata, 32'hFFFFFFDE);
    do_req(1'b0, 3'b100, 32'hB, 32'h0, lat, err, wec);
    chk("lbu_data", resp_rdata, 32'h000000DE);
    do_req(1'b0, 3'b001, 32'h8, 32'h0, lat, err, wec);
    chk("lh_data", resp_rdata, 32'hFFFFBEEF);
    do_req(1'b0, 3'b101, 32'hA, 32'h0, lat, err, wec);
    chk("lhu_data", resp_rdata, 32'h0000DEAD);
    do_req(1'b0, 3'b010, 32'h8, 32'h0, lat, err, wec);
    chk("lw_data", resp_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(err), 32'd0);

    do_req(1'b1, 3'b000, 32'h9, 32'h00000012, lat, err, wec);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_ram2", ram[2], 32'hDEAD12EF);
    do_req(1'b1, 3'b001, 32'hA, 32'h00005678, lat, err, wec);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_we_cycles", 32'(wec), 32'd1);
    chk("sh_ram2", ram[2], 32'h567812EF);
    chk("ram1_kept", ram[1], 32'h01A5015A);
    chk("ram3_kept", ram[3], 32'h03A5035A);

    do_req(1'b0, 3'b010, 32'h6, 32'h0, lat, err, wec);
    chk("lw_mis_lat", 32'(lat), 32'd1);
    chk("lw_mis_err", 32'(err), 32'd1);
    do_req(1'b0, 3'b001, 32'h5, 32'h0, lat, err, wec);
    chk("lh_mis_err", 32'(err), 32'd1);
    chk("lh_mis_lat", 32'(lat), 32'd1);
    do_req(1'b1, 3'b010, 32'h102, 32'h11111111, lat, err, wec);
    chk("sw_range_err", 32'(err), 32'd1);
    chk("sw_range_we", 32'(wec), 32'd0);
    do_req(1'b1, 3'b010, 32'h100, 32'h11111111, lat, err, wec);
    chk("sw_word64_err", 32'(err), 32'd1);
    do_req(1'b0, 3'b011, 32'h0, 32'h0, lat, err, wec);
    chk("ld_f3_err", 32'(err), 32'd1);
    chk("ld_f3_lat", 32'(lat), 32'd1);
    do_req(1'b1, 3'b100, 32'h4, 32'h22, lat, err, wec);
    chk("st_f3_err", 32'(err), 32'd1);
    chk("st_f3_we", 32'(wec), 32'd0);
    chk("err_rdata_kept", resp_rdata, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'hFC, 32'h0, lat, err, wec);
    chk("lw_last_word_err", 32'(err), 32'd0);
    chk("lw_last_word", resp_rdata, 32'h3FA53F5A);

    // SB aborted by reset while in WR
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'hFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wr", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_we_drop", 32'(mem_we), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      chk("abort_no_resp", 32'(seen), 32'd0);
    end
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    chk("abort_ram4", ram[4], 32'h04A5045A);

    // Three loads with req_valid held high throughout
    ld_addr[0] = 32'h0; ld_f3[0] = 3'b010; ld_exp[0] = 32'h00A5005A;
    ld_addr[1] = 32'h6; ld_f3[1] = 3'b000; ld_exp[1] = 32'hFFFFFFA5;
    ld_addr[2] = 32'hE; ld_f3[2] = 3'b001; ld_exp[2] = 32'h000003A5;
    begin
      int s = 0;
      int r = 0;
      int acc_cnt = 0;
      logic acc;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = ld_f3[0]; req_addr = ld_addr[0];
      for (int c = 0; c < 40 && r < 3; c++) begin
        if (c > 0) @(negedge clk);
        if (resp_valid) begin
          chk("b2b_order", resp_rdata, ld_exp[r]);
          r++;
        end
        acc = req_ready && req_valid;
        @(posedge clk);
        #1;
        if (acc) begin
          acc_cnt++;
          s++;
          if (s < 3) begin
            req_funct3 = ld_f3[s]; req_addr = ld_addr[s];
          end else begin
            req_valid = 1'b0;
          end
        end
      end
      req_valid = 1'b0;
      chk("b2b_resp_count", 32'(r), 32'd3);
      chk("b2b_accept_count", 32'(acc_cnt), 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
